// File: rtl/gpu_pixel_writer.sv
// Rasteriser pixel sink: range-checks pixels, buffers {addr,rgb} in a small FIFO, drains to SRAM via req/ack.
// Latency: accept at edge N into an empty FIFO gives mem_req_o at edge N+1; pix_ready_o = !full.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_pixel_writer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [WIDTH-1:0]         next_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_nxt;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && (count != '0);
  assign rd_nxt   = rd_ptr + 1'b1;
  assign head_dat = mem[rd_ptr];
  // Entry behind the head, so the writer can reload without a bubble on pop.
  assign next_dat = mem[rd_nxt];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module gpu_pixel_writer #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int ADDR_BITS  = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         pix_valid_i,
  input  logic [`WIDTH_BITS-1:0]       x_i,
  input  logic [`HEIGHT_BITS-1:0]      y_i,
  input  logic [`CHANNEL_BITS-1:0]     r_i,
  input  logic [`CHANNEL_BITS-1:0]     g_i,
  input  logic [`CHANNEL_BITS-1:0]     b_i,
  output logic                         pix_ready_o,
  output logic                         mem_req_o,
  output logic [ADDR_BITS-1:0]         mem_addr_o,
  output logic [3*`CHANNEL_BITS-1:0]   mem_data_o,
  input  logic                         mem_ack_i,
  output logic                         busy_o,
  output logic [7:0]                   drop_cnt_o
);
  localparam int XW   = `WIDTH_BITS;
  localparam int YW   = `HEIGHT_BITS;
  localparam int DW   = 3*`CHANNEL_BITS;
  localparam int EW   = ADDR_BITS + DW;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LIM = XW'(SCREEN_W);
  localparam logic [YW-1:0] Y_LIM = YW'(SCREEN_H);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                full;
  logic [CNTW-1:0]     count;
  logic [EW-1:0]       head_dat;
  logic [EW-1:0]       next_dat;
  logic [EW-1:0]       push_dat;
  logic [EW-1:0]       load_dat;
  logic [ADDR_BITS-1:0] pix_addr;
  logic                off_screen;
  logic                accept;
  logic                push;
  logic                pop;
  logic                load;

  assign pix_ready_o = !full;
  assign accept      = pix_valid_i && pix_ready_o;
  assign off_screen  = (x_i >= X_LIM) || (y_i >= Y_LIM);
  assign push        = accept && !off_screen;
  assign pix_addr    = ADDR_BITS'(y_i) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(x_i);
  assign push_dat    = {pix_addr, r_i, g_i, b_i};
  assign mem_req_o   = (state == WRITE);
  assign busy_o      = (count != '0) || (state == WRITE);

  gpu_pixel_writer_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .next_dat (next_dat),
    .count    (count),
    .full     (full)
  );

  // The head entry stays in the FIFO until acked; on ack the register reloads
  // from the following entry, or straight from a same-cycle push.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_dat  = head_dat;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = WRITE;
          load      = 1'b1;
        end
      end
      WRITE: begin
        if (mem_ack_i) begin
          pop = 1'b1;
          if (count > CNTW'(1)) begin
            load     = 1'b1;
            load_dat = next_dat;
          end else if (push) begin
            load     = 1'b1;
            load_dat = push_dat;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mem_addr_o <= load_dat[EW-1 -: ADDR_BITS];
        mem_data_o <= load_dat[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_cnt_o <= '0;
    end else if (accept && off_screen && (drop_cnt_o != 8'hFF)) begin
      drop_cnt_o <= drop_cnt_o + 8'd1;
    end
  end
endmodule
